kpn_adder_process: RTL and testbench
====================================

Name: kpn_adder_process

Overview:
KPN process node that sits directly downstream of two channel FIFOs and directly upstream of one channel FIFO.
- Performs a blocking read of one token from each input channel.
- Adds the two tokens.
- Performs a blocking write of the sum to the output channel.
- Input FIFOs are first-word-fall-through: head word is valid on the data port whenever empty is low, and rd pops it.

Parameters:
- B, 16, data word width in bits (all channels)
- CW, 16, width of the token counter
- N_TOKENS, 0, number of sums to produce before halting; 0 = run forever

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- en  input  1  process enable; sampled only in WAIT_IN
- a_data  input  B  head word of input channel A
- a_empty  input  1  channel A FIFO empty flag
- a_rd  output  1  pop strobe to channel A FIFO
- b_data  input  B  head word of input channel B
- b_empty  input  1  channel B FIFO empty flag
- b_rd  output  1  pop strobe to channel B FIFO
- out_data  output  B  sum token to downstream FIFO
- out_full  input  1  downstream FIFO full flag
- out_wr  output  1  write strobe to downstream FIFO
- token_count  output  CW  number of sums written since reset
- ovf  output  1  sticky flag: at least one addition carried out of B bits
- done  output  1  high once N_TOKENS sums are written (N_TOKENS≠0)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = WAIT_IN
  - out_data, token_count = 0
  - ovf, done = 0
  - a_rd, b_rd, out_wr = 0
  - Any in-flight token is discarded; FIFO contents are not affected.
- FSM states: WAIT_IN, POP, PUSH.
- WAIT_IN:
  - If en & ~a_empty & ~b_empty & ~done: on the clock edge, register sum = a_data + b_data into out_data, update ovf, go to POP.
  - Otherwise stay in WAIT_IN. This is the blocking read: no pop while either channel is empty.
- POP:
  - a_rd = b_rd = 1 for exactly this one cycle (Moore, decoded from state).
  - Always go to PUSH next cycle.
  - a_rd and b_rd are always asserted together, never singly.
- PUSH:
  - out_wr = ~out_full (combinational from state and out_full).
  - out_data is held stable for the whole state.
  - On an edge with out_wr = 1: token_count += 1, go to WAIT_IN.
  - If token_count+1 == N_TOKENS and N_TOKENS ≠ 0, set done on the same edge.
  - While out_full = 1, stay in PUSH. This is the blocking write.
- Latency and throughput:
  - Inputs non-empty at cycle 0 → a_rd/b_rd at cycle 1 → out_wr at cycle 2 (if not full).
  - Maximum throughput is 1 token per 3 cycles.
- Arithmetic:
  - Unsigned B-bit add, result modulo 2^B (wrap).
  - ovf is set when the carry out of bit B-1 is 1. It clears only on reset.
- Enable and halt:
  - Deasserting en in POP or PUSH does not abort; the current token completes.
  - done = 1 holds the FSM in WAIT_IN until reset. done never clears otherwise.
- token_count wraps from 2^CW-1 to 0 when N_TOKENS = 0.
- Each input is popped exactly once per produced output token; no token duplication or loss except on reset.

Optional Feature:
- Macro: KPN_ADD_SAT_EN.
- Defined: the addition saturates. When carry out is 1, out_data = 2^B-1 (all ones), and ovf is still set.
- Undefined: the addition wraps modulo 2^B as specified above.

Test Plan:
- a=0x0003, b=0x0004, both non-empty, out_full=0, en=1 → a_rd/b_rd high one cycle at cycle 1; out_wr at cycle 2 with out_data=0x0007; token_count=1.
- a non-empty, b_empty=1 for 10 cycles, then b=0x0010 → no a_rd/b_rd during the wait; then out_data=a+0x0010; exactly one pop per channel.
- Sum ready, out_full=1 for 5 cycles → out_wr low, out_data held, state stays PUSH; out_wr pulses one cycle after out_full falls.
- a=0xFFFF, b=0x0002 → out_data=0x0001, ovf=1 (with KPN_ADD_SAT_EN: out_data=0xFFFF, ovf=1); ovf stays high on a following 1+1.
- N_TOKENS=2, 4 tokens queued per input → exactly 2 writes (sums of first two pairs); done=1 after the 2nd write; no further rd.
- reset_n pulled low during PUSH with out_full=1 → all outputs 0 immediately (asynchronous); after release, next pair processed normally with token_count starting from 1.

Source files
------------

// File: rtl/kpn_adder_process.sv
// -----------------------------------------------------------------------------
// kpn_adder_process
//
// Kahn-process-network adder node. It takes one token from each of two
// first-word-fall-through input FIFOs (blocking read), adds them, and writes
// the sum to one downstream FIFO (blocking write). Each token moves through
// three states: WAIT_IN (capture the sum), POP (pop both inputs), and PUSH
// (write the output). Peak throughput is therefore one token every three
// cycles.
//
// Parameters
//   B         data word width for all channels
//   CW        token counter width
//   N_TOKENS  number of sums to produce before halting (0 = run forever)
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   en                  process enable, sampled only in WAIT_IN
//   a_data/a_empty/a_rd input channel A (head word, empty flag, pop strobe)
//   b_data/b_empty/b_rd input channel B (head word, empty flag, pop strobe)
//   out_data/out_full/out_wr
//                       output channel (sum, downstream full flag, write strobe)
//   token_count         sums written since reset (wraps when N_TOKENS = 0)
//   ovf                 sticky flag: some addition carried out of B bits
//   done                N_TOKENS sums have been written (N_TOKENS != 0)
//
// Build option
//   KPN_ADD_SAT_EN      when defined, a carry out saturates the sum to all
//                       ones instead of wrapping. ovf is set either way.
// -----------------------------------------------------------------------------
module kpn_adder_process #(
    parameter int B        = 16,
    parameter int CW       = 16,
    parameter int N_TOKENS = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [B-1:0]  a_data,
    input  logic          a_empty,
    output logic          a_rd,
    input  logic [B-1:0]  b_data,
    input  logic          b_empty,
    output logic          b_rd,
    output logic [B-1:0]  out_data,
    input  logic          out_full,
    output logic          out_wr,
    output logic [CW-1:0] token_count,
    output logic          ovf,
    output logic          done
);

    typedef enum logic [1:0] {
        WAIT_IN = 2'd0,
        POP     = 2'd1,
        PUSH    = 2'd2
    } state_t;

    localparam logic [CW-1:0] N_TOK_C = CW'(N_TOKENS);
    localparam bit            HALT_EN = (N_TOKENS != 0);

    // The MSB of the result is the raw carry out. The low B bits are the
    // token to emit: wrapped, or saturated when the build option is set.
    function automatic logic [B:0] add_token(input logic [B-1:0] x, input logic [B-1:0] y);
        logic [B:0] s;
        s = {1'b0, x} + {1'b0, y};
`ifdef KPN_ADD_SAT_EN
        if (s[B]) begin
            s = {1'b1, {B{1'b1}}};
        end
`endif
        return s;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic            start_s;
    logic            pop_s;
    logic            wr_s;
    logic [B:0]      add_res_s;
    logic [CW-1:0]   count_inc_s;
    logic            done_hit_s;
    logic [B-1:0]    out_data_r;
    logic [CW-1:0]   token_count_r;
    logic            ovf_r;
    logic            done_r;

    // Adder and counter increment, evaluated every cycle.
    always_comb begin
        add_res_s   = add_token(a_data, b_data);
        count_inc_s = token_count_r + CW'(1);
        done_hit_s  = HALT_EN && (count_inc_s == N_TOK_C);
    end

    // Next-state and strobe decode. The pops are Moore outputs of POP. The
    // write depends on the state and on out_full.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        pop_s        = 1'b0;
        wr_s         = 1'b0;
        case (state_r)
            WAIT_IN: begin
                // Blocking read: leave WAIT_IN only when both heads are
                // valid, and never after the halt count has been reached.
                if (en && !a_empty && !b_empty && !done_r) begin
                    start_s      = 1'b1;
                    state_next_s = POP;
                end else begin
                    state_next_s = WAIT_IN;
                end
            end
            POP: begin
                pop_s        = 1'b1;
                state_next_s = PUSH;
            end
            PUSH: begin
                // Blocking write: hold the token until downstream has room.
                if (!out_full) begin
                    wr_s         = 1'b1;
                    state_next_s = WAIT_IN;
                end else begin
                    state_next_s = PUSH;
                end
            end
            default: begin
                state_next_s = WAIT_IN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= WAIT_IN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers: captured sum, sticky overflow, counter, halt flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r    <= {B{1'b0}};
            token_count_r <= {CW{1'b0}};
            ovf_r         <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            if (start_s) begin
                out_data_r <= add_res_s[B-1:0];
                if (add_res_s[B]) begin
                    ovf_r <= 1'b1;
                end
            end
            if (wr_s) begin
                token_count_r <= count_inc_s;
                if (done_hit_s) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign a_rd        = pop_s;
    assign b_rd        = pop_s;
    assign out_wr      = wr_s;
    assign out_data    = out_data_r;
    assign token_count = token_count_r;
    assign ovf         = ovf_r;
    assign done        = done_r;

endmodule

// File: tb/tb_kpn_adder_process.sv
// -----------------------------------------------------------------------------
// tb_kpn_adder_process
//
// Self-checking bench for kpn_adder_process. The bench models the input
// FIFOs as queues. Each observed pop moves the head pair into an in-flight
// scoreboard. Each observed write is compared with the arithmetic sum of
// that pair. A second instance with N_TOKENS = 2 exercises the halt
// behaviour on a fixed set of four queued pairs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kpn_adder_process;

    logic        clk = 1'b0;
    logic        reset_n, en, a_empty, b_empty, out_full;
    logic [15:0] a_data, b_data;
    logic        a_rd, b_rd, out_wr, ovf, done;
    logic [15:0] out_data;
    logic [3:0]  token_count;

    logic        rst2_n, en2, a2_empty, b2_empty, out_full2;
    logic [15:0] a2_data, b2_data;
    logic        a2_rd, b2_rd, out_wr2, ovf2, done2;
    logic [15:0] out_data2;
    logic [15:0] token_count2;

    always #5 clk = ~clk;

    kpn_adder_process #(.B(16), .CW(4), .N_TOKENS(0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .a_data(a_data), .a_empty(a_empty), .a_rd(a_rd),
        .b_data(b_data), .b_empty(b_empty), .b_rd(b_rd),
        .out_data(out_data), .out_full(out_full), .out_wr(out_wr),
        .token_count(token_count), .ovf(ovf), .done(done)
    );

    kpn_adder_process #(.B(16), .CW(16), .N_TOKENS(2)) dut2 (
        .clk(clk), .reset_n(rst2_n), .en(en2),
        .a_data(a2_data), .a_empty(a2_empty), .a_rd(a2_rd),
        .b_data(b2_data), .b_empty(b2_empty), .b_rd(b2_rd),
        .out_data(out_data2), .out_full(out_full2), .out_wr(out_wr2),
        .token_count(token_count2), .ovf(ovf2), .done(done2)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] a_q[$], b_q[$], fly_a[$], fly_b[$];
    int          n_wr = 0;
    logic        ovf_m = 1'b0;
    logic        s_ard, s_brd, s_wr;
    logic [15:0] s_data;
    logic [15:0] a2_tok[4], b2_tok[4];
    int          idx2 = 0;
    int          wr2_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_sum(input int a, input int b);
        int s;
        s = a + b;
`ifdef KPN_ADD_SAT_EN
        if (s > 65535) s = 65535;
`endif
        return 16'(s % 65536);
    endfunction

    function automatic logic ref_carry(input int a, input int b);
        return (a + b) > 65535;
    endfunction

    task automatic drive();
        a_empty  = (a_q.size() == 0);
        b_empty  = (b_q.size() == 0);
        a_data   = a_empty ? 16'h0000 : a_q[0];
        b_data   = b_empty ? 16'h0000 : b_q[0];
        a2_empty = (idx2 >= 4);
        b2_empty = (idx2 >= 4);
        a2_data  = (idx2 < 4) ? a2_tok[idx2] : 16'h0000;
        b2_data  = (idx2 < 4) ? b2_tok[idx2] : 16'h0000;
    endtask

    task automatic enq(input logic [15:0] av, input logic [15:0] bv);
        a_q.push_back(av);
        b_q.push_back(bv);
        drive();
    endtask

    // One clock: sample at the falling edge, then apply FIFO effects and
    // re-drive inputs 1 ns after the rising edge.
    task automatic tick();
        logic        p2, w2;
        logic [15:0] ea, eb;
        @(negedge clk);
        s_ard  = a_rd;
        s_brd  = b_rd;
        s_wr   = out_wr;
        s_data = out_data;
        p2     = a2_rd;
        w2     = out_wr2;
        if (s_ard || s_brd) begin
            check_eq("rd_together", s_brd, s_ard);
            check_eq("pop_a_nonempty", a_q.size() != 0, 1);
            check_eq("pop_b_nonempty", b_q.size() != 0, 1);
            check_eq("single_inflight", fly_a.size(), 0);
            if (a_q.size() != 0 && b_q.size() != 0) begin
                fly_a.push_back(a_q[0]);
                fly_b.push_back(b_q[0]);
            end
        end
        if (s_wr) begin
            check_eq("wr_has_pop", fly_a.size() != 0, 1);
            if (fly_a.size() != 0) begin
                ea = fly_a.pop_front();
                eb = fly_b.pop_front();
                if (ref_carry(int'(ea), int'(eb))) ovf_m = 1'b1;
                check_eq("out_data", s_data, ref_sum(int'(ea), int'(eb)));
                check_eq("ovf", ovf, ovf_m);
                n_wr++;
            end
        end
        if (p2) check_eq("rd2_together", b2_rd, p2);
        if (w2) begin
            if (wr2_n < 4) check_eq("out_data2", out_data2, ref_sum(int'(a2_tok[wr2_n]), int'(b2_tok[wr2_n])));
            wr2_n++;
        end
        @(posedge clk);
        #1;
        if (s_ard && a_q.size() != 0) void'(a_q.pop_front());
        if (s_brd && b_q.size() != 0) void'(b_q.pop_front());
        if (s_wr) check_eq("token_count", token_count, n_wr % 16);
        if (p2) idx2++;
        drive();
    endtask

    task automatic run_to_write(input int max_cycles);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!s_wr && k < max_cycles);
        check_eq("write_seen", s_wr, 1);
    endtask

    initial begin
        logic [15:0] ta, tb;
        int          k;
        for (int i = 0; i < 4; i++) begin
            a2_tok[i] = 16'($urandom_range(0, 65535));
            b2_tok[i] = 16'($urandom_range(0, 65535));
        end
        reset_n = 1'b0; rst2_n = 1'b0; en = 1'b0; en2 = 1'b0;
        out_full = 1'b0; out_full2 = 1'b0;
        drive();
        #12;
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_count", token_count, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_strobes", {a_rd, b_rd, out_wr}, 0);
        check_eq("rst_done2", done2, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; rst2_n = 1'b1; en = 1'b1; en2 = 1'b1;

        // Basic latency: pop in cycle 1, write in cycle 2.
        enq(16'h0003, 16'h0004);
        tick(); check_eq("t1_c0_rd", s_ard, 0);
        tick(); check_eq("t1_c1_rd", s_ard & s_brd, 1); check_eq("t1_c1_wr", s_wr, 0);
        tick(); check_eq("t1_c2_wr", s_wr, 1); check_eq("t1_c2_data", s_data, 16'h0007);
        check_eq("t1_count", token_count, 1);
        tick(); check_eq("t1_c3_rd", s_ard, 0);

        // Blocking read: A has a token, B stays empty for 10 cycles.
        a_q.push_back(16'($urandom_range(0, 4096))); drive();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t2_no_pop", s_ard | s_brd, 0);
        end
        b_q.push_back(16'h0010); drive();
        run_to_write(8);
        check_eq("t2_drained", a_q.size() + b_q.size(), 0);

        // Blocking write: downstream full for 5 cycles in PUSH.
        out_full = 1'b1;
        ta = 16'h1234; tb = 16'h0101;
        enq(ta, tb);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t3_wr_held", s_wr, 0);
            check_eq("t3_data_held", s_data, ref_sum(int'(ta), int'(tb)));
        end
        out_full = 1'b0;
        tick(); check_eq("t3_wr_after_full", s_wr, 1);

        // Carry out, then a small sum: ovf must stay set.
        enq(16'hFFFF, 16'h0002);
        run_to_write(6);
        check_eq("t4_ovf", ovf, 1);
`ifdef KPN_ADD_SAT_EN
        check_eq("t4_data", s_data, 16'hFFFF);
`else
        check_eq("t4_data", s_data, 16'h0001);
`endif
        enq(16'h0001, 16'h0001);
        run_to_write(6);
        check_eq("t4_ovf_sticky", ovf, 1);
        check_eq("t4_data2", s_data, 16'h0002);

        // Asynchronous reset in PUSH while the output is full.
        out_full = 1'b1;
        enq(16'h0050, 16'h0060);
        tick(); tick(); tick();
        reset_n = 1'b0;
        #2;
        check_eq("t6_rst_data", out_data, 0);
        check_eq("t6_rst_count", token_count, 0);
        check_eq("t6_rst_ovf", ovf, 0);
        check_eq("t6_rst_strobes", {a_rd, b_rd, out_wr}, 0);
        fly_a.delete(); fly_b.delete();
        n_wr = 0; ovf_m = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; out_full = 1'b0;
        enq(16'h0700, 16'h0011);
        run_to_write(6);
        check_eq("t6_count_after_rst", token_count, 1);

        // Randomized traffic with random enable and back-pressure.
        for (int i = 0; i < 400; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0 && a_q.size() < 8)
                a_q.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom_range(65000, 65535)) : 16'($urandom_range(0, 65535)));
            if ($urandom_range(0, 3) == 0 && b_q.size() < 8)
                b_q.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom_range(65000, 65535)) : 16'($urandom_range(0, 65535)));
            out_full = ($urandom_range(0, 2) == 0);
            en       = ($urandom_range(0, 4) != 0);
            drive();
        end
        en = 1'b1; out_full = 1'b0; drive();
        k = 0;
        while (((a_q.size() != 0 && b_q.size() != 0) || fly_a.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check_eq("drain_complete", (a_q.size() == 0 || b_q.size() == 0) && fly_a.size() == 0, 1);
        check_eq("random_wrote_some", n_wr > 16, 1);
        check_eq("done_never_n0", done, 0);

        // Halting instance: exactly two pairs consumed and written.
        check_eq("n2_writes", wr2_n, 2);
        check_eq("n2_pops", idx2, 2);
        check_eq("n2_done", done2, 1);
        check_eq("n2_count", token_count2, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
